// File: rtl/sysbus_pkg.sv
// Shared sysbus definitions: tag field layout, line geometry and the
// memory-responder FSM state type.
package sysbus_pkg;

    localparam int TAG_WRITE_BIT = 12;
    localparam int TAG_TYPE_HI   = 11;
    localparam int TAG_TYPE_LO   = 8;

    localparam logic [3:0] TYPE_MEMORY = 4'b0001;

    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_BYTES     = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_RWAIT,
        S_RRESP
    } state_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port synchronous word RAM with write enable; read data is
// registered and reflects the word addressed on the previous cycle.
module sysbus_mem_array #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Slave end of the sysbus request/response port: line writes into a word
// RAM and line reads returned as eight tagged response beats.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int DEPTH_WORDS    = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW         = $clog2(DEPTH_WORDS);
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int LW         = AW - 3;
    localparam int LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_LINE - 1);

    state_t                   state, state_next;
    logic [2:0]               beat, beat_next;
    logic [LAT_W-1:0]         lat_cnt, lat_cnt_next;
    logic [LW-1:0]            base, base_next;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_next;
    logic                     respcyc_q;

    logic                      xfer;
    logic                      ram_we;
    logic [AW-1:0]             ram_addr;
    logic [BUS_DATA_WIDTH-1:0] ram_rdata;
    logic [LW-1:0]             req_line;
    logic [3:0]                req_type;

    // Line index of the address beat; offset bits and bits above the array wrap away.
    assign req_line = bus_req[LINE_SHIFT+LW-1:LINE_SHIFT];
    assign req_type = bus_reqtag[TAG_TYPE_HI:TAG_TYPE_LO];

    assign bus_reqack = !reset && bus_reqcyc && (state == S_IDLE || state == S_WDATA);
    assign xfer       = bus_reqcyc && bus_reqack;

    always_comb begin
        state_next   = state;
        beat_next    = beat;
        lat_cnt_next = lat_cnt;
        base_next    = base;
        tag_next     = tag_q;
        ram_we       = 1'b0;
        ram_addr     = {base, 3'd0};
        case (state)
            S_IDLE: begin
                ram_addr = {req_line, 3'd0};
                if (xfer && req_type == TYPE_MEMORY) begin
                    base_next = req_line;
                    beat_next = 3'd0;
                    if (bus_reqtag[TAG_WRITE_BIT]) begin
                        state_next = S_WDATA;
                    end else begin
                        tag_next     = bus_reqtag;
                        lat_cnt_next = LAT_W'(READ_LATENCY - 1);
                        state_next   = (READ_LATENCY == 1) ? S_RRESP : S_RWAIT;
                    end
                end
            end
            S_WDATA: begin
                ram_addr = {base, beat};
                if (xfer) begin
                    ram_we    = 1'b1;
                    beat_next = beat + 3'd1;
                    if (beat == LAST_BEAT) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_RWAIT: begin
                // Leave one cycle early so the registered RAM read lands with respcyc.
                if (lat_cnt <= LAT_W'(1)) begin
                    state_next = S_RRESP;
                    beat_next  = 3'd0;
                end else begin
                    lat_cnt_next = lat_cnt - LAT_W'(1);
                end
            end
            S_RRESP: begin
                if (bus_respack) begin
                    beat_next = beat + 3'd1;
                    if (beat == LAST_BEAT) begin
                        state_next = S_IDLE;
                    end
                end
                ram_addr = {base, beat_next};
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            beat      <= 3'd0;
            lat_cnt   <= '0;
            base      <= '0;
            tag_q     <= '0;
            respcyc_q <= 1'b0;
        end else begin
            state     <= state_next;
            beat      <= beat_next;
            lat_cnt   <= lat_cnt_next;
            base      <= base_next;
            tag_q     <= tag_next;
            respcyc_q <= (state_next == S_RRESP);
        end
    end

    sysbus_mem_array #(
        .DATA_W      (BUS_DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus_req),
        .rdata (ram_rdata)
    );

    assign bus_respcyc = respcyc_q;
    assign bus_resp    = respcyc_q ? ram_rdata : '0;
    assign bus_resptag = respcyc_q ? tag_q : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed and randomized line traffic against a word-level memory model.
module tb_sysbus_mem_responder;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int DEPTH = 4096;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int passed = 0;
    int total  = 0;

    logic [63:0] model [int];

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .DEPTH_WORDS    (DEPTH),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word index of beat i of the line holding byte address addr.
    function automatic int widx(input logic [63:0] addr, input int i);
        int w;
        w = int'((addr >> 3) & 64'(DEPTH - 1));
        return (w & ~7) + i;
    endfunction

    // Drive one request beat and hold it until accepted; n = cycles waited.
    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int n);
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        n = 0;
        @(negedge clk);
        while (!bus_reqack && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] d [8]);
        int n;
        send_beat(addr, tag, n);
        chk("wr_addr_ack_wait", 64'(n), 64'd0);
        for (int i = 0; i < 8; i++) begin
            send_beat(d[i], tag, n);
            chk($sformatf("wr_data%0d_ack_wait", i), 64'(n), 64'd0);
            model[widx(addr, i)] = d[i];
        end
    endtask

    task automatic expect_line(input logic [63:0] addr, output logic [63:0] e [8]);
        for (int i = 0; i < 8; i++) e[i] = model[widx(addr, i)];
    endtask

    // Called right after a read address transfer. ack_mode: 0 always,
    // 1 pattern 1,0,0, 2 random. Returns early while beat abort_at is shown.
    task automatic collect(input logic [63:0] e [8], input logic [12:0] etag,
                           input int ack_mode, input bit pending, input int abort_at);
        int  c;
        int  j;
        int  cyc;
        bit  early;
        logic ack;
        c = 1;
        early = 1'b0;
        while (!bus_respcyc && c < 40) begin
            tick();
            c++;
        end
        chk("first_resp_latency", 64'(c), 64'(LAT));
        j = 0;
        cyc = 0;
        while (j < 8 && cyc < 200 && bus_respcyc) begin
            chk($sformatf("resp_beat%0d", j), bus_resp, e[j]);
            chk($sformatf("resp_tag%0d", j), 64'(bus_resptag), 64'(etag));
            if (j == abort_at) begin
                bus_respack = 1'b0;
                return;
            end
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            bus_respack = ack;
            if (pending) begin
                @(negedge clk);
                if (bus_reqack) early = 1'b1;
            end
            tick();
            if (ack) j++;
            cyc++;
        end
        bus_respack = 1'b0;
        chk("beats_consumed", 64'(j), 64'd8);
        chk("respcyc_low_after_last", 64'(bus_respcyc), 64'd0);
        if (pending) begin
            chk("reqack_held_low_during_resp", 64'(early), 64'd0);
            @(negedge clk);
            chk("reqack_after_last_beat", 64'(bus_reqack), 64'd1);
            @(posedge clk);
            #1;
            bus_reqcyc = 1'b0;
        end
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                             input int ack_mode);
        int n;
        logic [63:0] e [8];
        expect_line(addr, e);
        send_beat(addr, tag, n);
        chk("rd_addr_ack_wait", 64'(n), 64'd0);
        collect(e, tag, ack_mode, 1'b0, -1);
    endtask

    initial begin
        logic [63:0] d [8];
        logic [63:0] e [8];
        logic [63:0] e2 [8];
        logic [63:0] lines [$];
        int n;
        int cnt;

        reset       = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h1000;
        bus_reqtag  = 13'h0142;
        bus_respack = 1'b0;
        tick();
        tick();
        chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
        chk("reset_resp", bus_resp, 64'd0);
        chk("reset_resptag", 64'(bus_resptag), 64'd0);
        @(negedge clk);
        chk("reset_reqack", 64'(bus_reqack), 64'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus_reqcyc = 1'b0;
        tick();

        // Write then read with respack held high.
        for (int i = 0; i < 8; i++) d[i] = 64'hA0 + 64'(i);
        write_line(64'h1000, 13'h1101, d);
        read_line(64'h1000, 13'h0142, 0);

        // Backpressure on the response beats.
        read_line(64'h1000, 13'h0143, 1);

        // Non-memory target types are dropped without a data phase.
        send_beat(64'h1000, 13'h0342, n);
        chk("nonmem_rd_ack_wait", 64'(n), 64'd0);
        send_beat(64'h1040, 13'h1342, n);
        chk("nonmem_wr_ack_wait", 64'(n), 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_respcyc) cnt++;
            tick();
        end
        chk("nonmem_no_resp", 64'(cnt), 64'd0);
        read_line(64'h1000, 13'h0144, 0);

        // A request raised during RRESP waits for the return to IDLE.
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        write_line(64'h2000, 13'h1107, d);
        expect_line(64'h1000, e);
        expect_line(64'h2000, e2);
        send_beat(64'h1000, 13'h0150, n);
        chk("rd1_addr_ack_wait", 64'(n), 64'd0);
        bus_reqcyc = 1'b1;
        bus_req    = 64'h2000;
        bus_reqtag = 13'h0155;
        collect(e, 13'h0150, 0, 1'b1, -1);
        collect(e2, 13'h0155, 0, 1'b0, -1);

        // Offset bits ignored and address wraps onto line 0.
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
        write_line(64'h1003C, 13'h1101, d);
        expect_line(64'h0000, e);
        for (int i = 0; i < 8; i++) chk($sformatf("wrap_model%0d", i), e[i], d[i]);
        read_line(64'h0000, 13'h0160, 0);

        // Random line traffic, reads aliased through offset and wrap bits.
        for (int k = 0; k < 6; k++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
            write_line(a, 13'h1100 | 13'($urandom_range(0, 255)), d);
            lines.push_back(a);
        end
        for (int k = 0; k < 6; k++) begin
            logic [63:0] a;
            a = lines[$urandom_range(0, lines.size() - 1)];
            a = (a & 64'(DEPTH * 8 - 64)) | 64'($urandom_range(0, 63))
                | ({32'd0, $urandom} << 15);
            read_line(a, 13'h0100 | 13'($urandom_range(0, 255)), 2);
        end

        // Reset while beat 3 of a read is on the bus.
        expect_line(64'h2000, e2);
        send_beat(64'h2000, 13'h0170, n);
        chk("rst_rd_addr_ack_wait", 64'(n), 64'd0);
        collect(e2, 13'h0170, 0, 1'b0, 3);
        reset = 1'b1;
        tick();
        chk("midrst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("midrst_resp", bus_resp, 64'd0);
        bus_reqcyc = 1'b1;
        bus_req    = 64'h2000;
        bus_reqtag = 13'h01AA;
        @(negedge clk);
        chk("midrst_reqack", 64'(bus_reqack), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_beat(64'h2000, 13'h01AA, n);
        chk("postrst_addr_ack_wait", 64'(n), 64'd0);
        collect(e2, 13'h01AA, 0, 1'b0, -1);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
